// File: rtl/sram_multi_cdc_bridge.sv
// Multi-channel SRAM bridge: NCH asynchronous 4-phase req/ack requesters are synchronised and
// round-robin arbitrated onto one SRAM controller, with a per-transaction watchdog.
module sram_multi_cdc_bridge #(
    parameter int NCH         = 2,
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_we,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH*DW-1:0] ch_rdata,
    output logic [NCH-1:0]    ch_err,
    output logic              s_req,
    output logic              s_wr_req,
    output logic              s_rd_req,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    input  logic [DW-1:0]     s_rdata,
    input  logic              s_valid,
    input  logic              s_busy
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 2);
    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_WAIT = 1'b1;
    localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CYC);
    localparam logic [PW-1:0] PTR_RST = PW'(NCH - 1);

    logic [NCH-1:0]    req_sync_r   [SYNC_STAGES];
    logic [NCH-1:0]    we_sync_r    [SYNC_STAGES];
    logic [NCH*AW-1:0] addr_sync_r  [SYNC_STAGES];
    logic [NCH*DW-1:0] wdata_sync_r [SYNC_STAGES];

    logic [0:0]     state_r;
    logic [PW-1:0]  grant_r;
    logic [PW-1:0]  ptr_r;
    logic [TW-1:0]  timer_r;
    logic           first_r;
    logic           we_r;

    logic [NCH-1:0] rq_s;
    logic [NCH-1:0] grant_mask_s;
    logic [NCH-1:0] elig_s;
    logic [PW-1:0]  pick_s;
    logic           any_s;
    logic [AW-1:0]  sel_addr_s;
    logic [DW-1:0]  sel_wdata_s;
    logic           sel_we_s;
    logic [TW-1:0]  timer_inc_s;
    logic           done_s;
    logic           timeout_s;
    int             idx_s;

    // Every requester input crosses into s_clk through its own flop chain
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                req_sync_r[k]   <= {NCH{1'b0}};
                we_sync_r[k]    <= {NCH{1'b0}};
                addr_sync_r[k]  <= {(NCH*AW){1'b0}};
                wdata_sync_r[k] <= {(NCH*DW){1'b0}};
            end
        end else begin
            req_sync_r[0]   <= ch_req;
            we_sync_r[0]    <= ch_we;
            addr_sync_r[0]  <= ch_addr;
            wdata_sync_r[0] <= ch_wdata;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                req_sync_r[k]   <= req_sync_r[k-1];
                we_sync_r[k]    <= we_sync_r[k-1];
                addr_sync_r[k]  <= addr_sync_r[k-1];
                wdata_sync_r[k] <= wdata_sync_r[k-1];
            end
        end
    end

    assign rq_s        = req_sync_r[SYNC_STAGES-1];
    assign elig_s      = rq_s & ~ch_ack & ~grant_mask_s;
    assign sel_addr_s  = addr_sync_r[SYNC_STAGES-1][pick_s*AW +: AW];
    assign sel_wdata_s = wdata_sync_r[SYNC_STAGES-1][pick_s*DW +: DW];
    assign sel_we_s    = we_sync_r[SYNC_STAGES-1][pick_s];
    assign timer_inc_s = timer_r + TW'(1'b1);
    assign timeout_s   = (TIMEOUT_CYC != 0) && (timer_inc_s == TO_LIM);
    // Writes finish on the first idle SRAM cycle after the pulse cycle; reads on s_valid
    assign done_s      = we_r ? (~first_r & ~s_busy) : s_valid;

    // Round-robin pick: scanning from farthest to nearest leaves the first index after ptr_r
    always_comb begin
        grant_mask_s = {NCH{1'b0}};
        any_s        = 1'b0;
        pick_s       = ptr_r;
        idx_s        = 0;
        for (int i = 0; i < NCH; i++) begin
            grant_mask_s[i] = (state_r != ST_IDLE) && (grant_r == PW'(i));
        end
        for (int k = NCH; k >= 1; k--) begin
            idx_s  = (int'(ptr_r) + k) % NCH;
            any_s  = any_s | elig_s[idx_s];
            pick_s = elig_s[idx_s] ? PW'(idx_s) : pick_s;
        end
    end

    // Transaction FSM, SRAM-side outputs and per-channel handshake outputs
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_r  <= ST_IDLE;
            grant_r  <= {PW{1'b0}};
            ptr_r    <= PTR_RST;
            timer_r  <= {TW{1'b0}};
            first_r  <= 1'b0;
            we_r     <= 1'b0;
            ch_ack   <= {NCH{1'b0}};
            ch_err   <= {NCH{1'b0}};
            ch_rdata <= {(NCH*DW){1'b0}};
            s_req    <= 1'b0;
            s_wr_req <= 1'b0;
            s_rd_req <= 1'b0;
            s_addr   <= {AW{1'b0}};
            s_wdata  <= {DW{1'b0}};
        end else begin
            s_wr_req <= 1'b0;
            s_rd_req <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (ch_ack[i] && !rq_s[i]) begin
                    ch_ack[i] <= 1'b0;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (any_s && !s_busy) begin
                        grant_r  <= pick_s;
                        ptr_r    <= pick_s;
                        s_addr   <= sel_addr_s;
                        s_wdata  <= sel_wdata_s;
                        we_r     <= sel_we_s;
                        s_wr_req <= sel_we_s;
                        s_rd_req <= ~sel_we_s;
                        s_req    <= 1'b1;
                        timer_r  <= {TW{1'b0}};
                        first_r  <= 1'b1;
                        state_r  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    first_r <= 1'b0;
                    // Completion is tested first so it wins over a same-cycle timeout
                    if (done_s) begin
                        ch_ack[grant_r] <= 1'b1;
                        ch_err[grant_r] <= 1'b0;
                        if (!we_r) begin
                            ch_rdata[grant_r*DW +: DW] <= s_rdata;
                        end
                        s_req   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (timeout_s) begin
                        ch_ack[grant_r]            <= 1'b1;
                        ch_err[grant_r]            <= 1'b1;
                        ch_rdata[grant_r*DW +: DW] <= {DW{1'b1}};
                        s_req                      <= 1'b0;
                        state_r                    <= ST_IDLE;
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    s_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
